menu_input_ctl: RTL and testbench
=================================

MENU_INPUT_CTL -- requirements
Module: menu_input_ctl

Interface
REQ-001 The module SHALL have exactly one clock, `clk`, and one reset, `rst`; `rst` is asynchronous and active-low.
REQ-002 Parameter `DEBOUNCE_CYCLES`, default 2_000_000: number of consecutive stable cycles before a button changes state.
REQ-003 Parameter `REPEAT_DELAY`, default 50_000_000: number of hold cycles from press to the first auto-repeat strobe.
REQ-004 Parameter `REPEAT_PERIOD`, default 20_000_000: number of cycles between later auto-repeat strobes.
REQ-005 Ports SHALL be:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_center`  in  1 each  raw asynchronous buttons, active-high
- `top`, `bottom`, `left`, `right`  out  1 each  one-cycle direction strobes to the game menu controller
- `mouse_left`  out  1  one-cycle select strobe, driven by `btn_center`

Function
REQ-006 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-007 Each button SHALL hold a debounced state `db`, reset to 0.
- A counter SHALL increment while the synchronized input differs from `db`.
- The counter SHALL clear on any cycle where the input equals `db`.
- On reaching `DEBOUNCE_CYCLES`−1, `db` SHALL take the synchronized value and the counter SHALL clear.
REQ-008 A `db` 0→1 transition SHALL raise a press event, registered.
- With a clean step held stable, the strobe SHALL be high exactly `DEBOUNCE_CYCLES`+3 rising edges after the raw edge, for exactly 1 cycle.
REQ-009 A `db` 1→0 transition SHALL produce no strobe.
REQ-010 A glitch shorter than `DEBOUNCE_CYCLES` cycles SHALL produce no strobe and leave `db` unchanged.
REQ-011 Direction buttons SHALL auto-repeat; a hold counter runs while `db`=1.
- First repeat strobe: `REPEAT_DELAY` cycles after the press strobe.
- Later strobes: every `REPEAT_PERIOD` cycles.
- `db`→0 SHALL clear the hold counter immediately, with no further strobes.
REQ-012 `btn_center` SHALL never auto-repeat; one press produces exactly one `mouse_left` pulse.
REQ-013 At most one output SHALL be high in any cycle.
- Priority: `mouse_left` > `bottom` > `top` > `right` > `left`.
- Losing events in that cycle SHALL be dropped, not queued.
REQ-014 Counters SHALL be 27-bit unsigned and saturate, never wrap.
- The hold counter SHALL restart its period after each repeat strobe.
REQ-015 Opposing buttons held together SHALL be handled independently, subject only to REQ-013.

Reset
REQ-016 While `rst`=0, the following SHALL be 0 asynchronously:
- all outputs
- synchronizer flops
- `db` registers
- all counters
REQ-017 A button held through reset release SHALL be debounced from scratch and produce a normal press strobe after `DEBOUNCE_CYCLES`+3 edges.
REQ-018 Reset asserted mid-debounce or mid-repeat SHALL abort it, with no strobe emitted during or in the cycle after reset.

Structure
REQ-019 A shared package SHALL hold:
- the button index enum (CENTER, DOWN, UP, RIGHT, LEFT, in priority order)
- the counter-width constant (27)
- the default timing constants
REQ-020 One sub-module, `button_debounce`, SHALL implement synchronizer, debounce, press edge and optional repeat (parameter `REPEAT_EN`).
- It SHALL be instantiated five times; arbitration stays in the top level.

Verification
Benches SHALL use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
REQ-021 `btn_up` clean step held 10 cycles then released -> `top` high for 1 cycle at edge 7 after the step; no other strobes.
REQ-022 `btn_left` 3-cycle glitch, then low -> no strobe ever; `left` debounced state stays 0.
REQ-023 `btn_right` held 60 cycles -> `right` strobes at edges 7, 27, 35, 43, 51, 59; none after release.
REQ-024 `btn_center` held 60 cycles -> exactly one `mouse_left` pulse, at edge 7.
REQ-025 `btn_center` and `btn_down` stepped in the same cycle -> `mouse_left` pulses at edge 7; `bottom` does not pulse at edge 7; `bottom` repeats start at edge 27.
REQ-026 `btn_up` held and `rst` pulsed low at edge 5 then released -> no `top` strobe before reset; `top` pulses `DEBOUNCE_CYCLES`+3 edges after reset release.

Source files
------------

// File: rtl/menu_input_ctl_pkg.sv
// rtl/menu_input_ctl_pkg.sv - shared constants, button indices and counter helpers for menu_input_ctl
//
// Contents:
//   CNT_W / cnt_t         width and type of every debounce and hold counter
//   DEF_*                 default timing constants (cycles)
//   btn_idx_e             button index, ordered by output priority (CENTER highest)
//   rep_state_e           auto-repeat sequencer states
//   sat_inc / to_cnt      saturating increment and clamped parameter conversion
package menu_input_ctl_pkg;

    localparam int          CNT_W    = 27;
    localparam int          NUM_BTNS = 5;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;

    typedef logic [CNT_W-1:0] cnt_t;

    // Lower index wins arbitration.
    typedef enum logic [2:0] {
        BTN_CENTER = 3'd0,
        BTN_DOWN   = 3'd1,
        BTN_UP     = 3'd2,
        BTN_RIGHT  = 3'd3,
        BTN_LEFT   = 3'd4
    } btn_idx_e;

    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,   // button released (or repeat disabled)
        REP_FIRST = 2'd1,   // held, waiting for the first repeat
        REP_NEXT  = 2'd2    // held, repeating at the steady period
    } rep_state_e;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
    endfunction

    // Parameters larger than the counter can hold clamp to the maximum.
    function automatic cnt_t to_cnt(input int unsigned v);
        return (v > CNT_MAX) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/menu_input_ctl_button.sv
// rtl/menu_input_ctl_button.sv - per-button synchronizer, debouncer, press edge and optional auto-repeat
//
// Module button_debounce
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   btn_i     raw asynchronous button, active-high
//   strobe_o  registered one-cycle pulse: press, or auto-repeat while held
//
// Timing from a clean raw step: two synchronizer edges, DEBOUNCE_CYCLES
// edges to accept the new level, one edge to register the press pulse,
// i.e. strobe_o is high DEBOUNCE_CYCLES+3 edges after the step.
module button_debounce
    import menu_input_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic strobe_o
);

    localparam cnt_t DB_LAST      = (DEBOUNCE_CYCLES == 0) ? '0 : to_cnt(DEBOUNCE_CYCLES - 1);
    localparam cnt_t REP_DELAY_C  = to_cnt(REPEAT_DELAY);
    localparam cnt_t REP_PERIOD_C = to_cnt(REPEAT_PERIOD);

    logic       sync1_q, sync2_q;
    logic       db_q, db_d;
    logic       db_dly_q;
    cnt_t       db_cnt_q, db_cnt_d;
    cnt_t       hold_q, hold_d;
    rep_state_e state_q, state_d;
    logic       press_rise;
    logic       rep_fire;
    logic       strobe_q, strobe_d;

    // Two-flop synchronizer; nothing else looks at btn_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // The counter measures how long the synchronized level has disagreed
    // with db; any agreeing sample restarts the count, so short glitches
    // never reach DB_LAST.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q >= DB_LAST) begin
                db_d     = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = sat_inc(db_cnt_q);
            end
        end
    end

    assign press_rise = db_q & ~db_dly_q;

    // Hold counter counts cycles since the press pulse (or the last repeat);
    // it is 1 in the cycle the press pulse is visible, so comparing against
    // REPEAT_DELAY lands the first repeat exactly REPEAT_DELAY cycles later.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rep_fire = 1'b0;
        case (state_q)
            REP_IDLE: begin
                hold_d = '0;
                if (REPEAT_EN && db_q) begin
                    state_d = REP_FIRST;
                    hold_d  = cnt_t'(1);
                end
            end
            REP_FIRST, REP_NEXT: begin
                if (!db_q) begin
                    state_d = REP_IDLE;
                    hold_d  = '0;
                end else if (hold_q == ((state_q == REP_FIRST) ? REP_DELAY_C : REP_PERIOD_C)) begin
                    rep_fire = 1'b1;
                    state_d  = REP_NEXT;
                    hold_d   = cnt_t'(1);
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end
            default: begin
                state_d = REP_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign strobe_d = press_rise | rep_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            db_cnt_q <= '0;
            hold_q   <= '0;
            state_q  <= REP_IDLE;
            strobe_q <= 1'b0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            db_cnt_q <= db_cnt_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/menu_input_ctl.sv
// rtl/menu_input_ctl.sv - five-button menu input front end with debounce, auto-repeat and priority arbitration
//
// Module menu_input_ctl
//   clk                                   system clock
//   rst                                   asynchronous active-low reset
//   btn_up/down/left/right/center         raw asynchronous buttons, active-high
//   top/bottom/left/right                 one-cycle direction strobes (auto-repeating)
//   mouse_left                            one-cycle select strobe from btn_center (no repeat)
//
// At most one output is high per cycle; priority is
// mouse_left > bottom > top > right > left and losing strobes are dropped.
module menu_input_ctl
    import menu_input_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_center,
    output logic top,
    output logic bottom,
    output logic left,
    output logic right,
    output logic mouse_left
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] strobe;
    logic [NUM_BTNS-1:0] grant;

    assign raw[BTN_CENTER] = btn_center;
    assign raw[BTN_DOWN]   = btn_down;
    assign raw[BTN_UP]     = btn_up;
    assign raw[BTN_RIGHT]  = btn_right;
    assign raw[BTN_LEFT]   = btn_left;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b0)
    ) u_center (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (raw[BTN_CENTER]),
        .strobe_o(strobe[BTN_CENTER])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b1)
    ) u_down (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (raw[BTN_DOWN]),
        .strobe_o(strobe[BTN_DOWN])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b1)
    ) u_up (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (raw[BTN_UP]),
        .strobe_o(strobe[BTN_UP])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b1)
    ) u_right (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (raw[BTN_RIGHT]),
        .strobe_o(strobe[BTN_RIGHT])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b1)
    ) u_left (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (raw[BTN_LEFT]),
        .strobe_o(strobe[BTN_LEFT])
    );

    // Indices follow priority, so isolating the lowest set bit is the
    // arbitration. The strobes are registers, so the outputs are glitch-free
    // and forced low while reset is asserted.
    assign grant = strobe & (~strobe + NUM_BTNS'(1));

    assign mouse_left = grant[BTN_CENTER];
    assign bottom     = grant[BTN_DOWN];
    assign top        = grant[BTN_UP];
    assign right      = grant[BTN_RIGHT];
    assign left       = grant[BTN_LEFT];

endmodule

// File: tb/tb_menu_input_ctl.sv
// tb/tb_menu_input_ctl.sv - scoreboard bench for menu_input_ctl
module tb_menu_input_ctl;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int NB   = 5;
    localparam int MAXT = 140;

    // Button / output codes, highest priority first:
    // 0 center/mouse_left, 1 down/bottom, 2 up/top, 3 right/right, 4 left/left
    typedef struct {
        int at;
        int code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
    logic top, bottom, left, right, mouse_left;

    exp_t exp_q[$];
    exp_t dir_q[$];
    logic wave [NB][MAXT+1];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int end_req = 0;
    int end_seen = 0;
    int end_kind = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    menu_input_ctl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .top       (top),
        .bottom    (bottom),
        .left      (left),
        .right     (right),
        .mouse_left(mouse_left)
    );

    // Monitor: the only process that counts comparisons.
    always @(negedge clk) begin
        logic [4:0] o;
        int   code;
        exp_t e;
        o = {left, right, top, bottom, mouse_left};
        if (!rst) begin
            n_cmp++;
            if (o != 5'b0) begin
                n_err++;
                $display("FAIL reset_outputs: cyc %0d got %b required 00000", cyc, o);
            end
        end else if (o != 5'b0) begin
            n_cmp++;
            if ($countones(o) != 1) begin
                n_err++;
                $display("FAIL one_hot: cyc %0d got %b required at most one bit", cyc, o);
            end
            code = -1;
            for (int i = NB - 1; i >= 0; i--) if (o[i]) code = i;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: cyc %0d got code %0d required none", cyc, code);
            end else begin
                e = exp_q.pop_front();
                if (e.at != cyc || e.code != code) begin
                    n_err++;
                    $display("FAIL strobe_match: got code %0d at cyc %0d required code %0d at cyc %0d",
                             code, cyc, e.code, e.at);
                end
            end
        end
        if (end_req != end_seen) begin
            end_seen = end_req;
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_strobes: %0d left, next code %0d at cyc %0d required 0 left",
                         exp_q.size(), exp_q[0].code, exp_q[0].at);
                exp_q.delete();
            end
            if (end_kind == 1) begin
                n_cmp++;
                if (dut.u_left.db_q !== 1'b0) begin
                    n_err++;
                    $display("FAIL left_db_after_glitch: got %b required 0", dut.u_left.db_q);
                end
            end
        end
    end

    task automatic clear_wave();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k <= MAXT; k++) wave[b][k] = 1'b0;
        dir_q.delete();
    endtask

    task automatic hold_btn(input int b, input int from, input int to);
        for (int k = from; k <= to; k++) wave[b][k] = 1'b1;
    endtask

    task automatic want(input int at, input int code);
        exp_t e;
        e.at   = at;
        e.code = code;
        dir_q.push_back(e);
    endtask

    task automatic set_raw(input int k);
        btn_center = wave[0][k];
        btn_down   = wave[1][k];
        btn_up     = wave[2][k];
        btn_right  = wave[3][k];
        btn_left   = wave[4][k];
    endtask

    task automatic rand_wave(input int len);
        logic level;
        int   k;
        int   seg;
        clear_wave();
        for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 3) != 0) begin
                level = 1'($urandom_range(0, 1));
                k = 1;
                while (k <= len) begin
                    if ($urandom_range(0, 2) == 0) seg = int'($urandom_range(1, D));
                    else                           seg = int'($urandom_range(D + 1, 45));
                    for (int i = 0; i < seg && k <= len; i++) begin
                        wave[b][k] = level;
                        k++;
                    end
                    level = ~level;
                end
            end
        end
    endtask

    // Synchronized sample seen by the debouncer at edge t (raw value two edges earlier).
    function automatic logic samp(input int b, input int t);
        if (t - 2 < 1) return 1'b0;
        return wave[b][t-2];
    endfunction

    // Reference: a button's level is accepted once D consecutive synchronized
    // samples disagree with it; press pulse one edge after acceptance; direction
    // buttons repeat RD after the press then every RP while still accepted high;
    // each edge the highest-priority candidate wins, the rest are dropped.
    task automatic model_push(input int base, input int tot);
        logic dbv  [NB][MAXT+1];
        logic cand [NB][MAXT+1];
        logic all_diff;
        logic found;
        logic alive;
        int   r;
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            dbv[b][0]  = 1'b0;
            cand[b][0] = 1'b0;
            for (int t = 1; t <= tot; t++) begin
                dbv[b][t]  = dbv[b][t-1];
                cand[b][t] = 1'b0;
                all_diff   = (t >= D);
                for (int j = 0; j < D; j++)
                    if (t - j >= 1 && samp(b, t - j) == dbv[b][t-1]) all_diff = 1'b0;
                if (all_diff) dbv[b][t] = ~dbv[b][t-1];
            end
            for (int t = 2; t <= tot; t++) begin
                if (dbv[b][t-1] && !dbv[b][t-2]) begin
                    cand[b][t] = 1'b1;
                    if (b != 0) begin
                        r     = t + RD;
                        alive = 1'b1;
                        while (alive && r <= tot) begin
                            for (int s = t - 1; s <= r - 1; s++) if (!dbv[b][s]) alive = 1'b0;
                            if (alive) begin
                                cand[b][r] = 1'b1;
                                r = r + RP;
                            end
                        end
                    end
                end
            end
        end
        for (int t = 1; t <= tot; t++) begin
            found = 1'b0;
            for (int b = 0; b < NB; b++) begin
                if (!found && cand[b][t]) begin
                    found  = 1'b1;
                    e.at   = base + t;
                    e.code = b;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_scn(input int tot, input int pre, input bit use_model, input int ekind);
        int   base;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        btn_center = 1'b0; btn_down = 1'b0; btn_up = 1'b0; btn_right = 1'b0; btn_left = 1'b0;
        repeat (2) @(negedge clk);
        if (pre > 0) begin
            rst = 1'b1;
            set_raw(1);
            repeat (pre) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
        end
        rst = 1'b1;
        set_raw(1);
        base = cyc;
        if (use_model) begin
            model_push(base, tot);
        end else begin
            foreach (dir_q[i]) begin
                e.at   = base + dir_q[i].at;
                e.code = dir_q[i].code;
                exp_q.push_back(e);
            end
        end
        for (int k = 2; k <= tot; k++) begin
            @(negedge clk);
            set_raw(k);
        end
        repeat (4) @(negedge clk);
        end_kind = ekind;
        end_req  = end_req + 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clear_wave();
        repeat (3) @(negedge clk);

        // up step held 10 cycles: one top at edge 7
        clear_wave(); hold_btn(2, 1, 10);
        want(7, 2);
        run_scn(80, 0, 1'b0, 0);

        // left 3-cycle glitch: nothing, db stays 0
        clear_wave(); hold_btn(4, 1, 3);
        run_scn(80, 0, 1'b0, 1);

        // right held 60: 7, 27, 35, 43, 51, 59
        clear_wave(); hold_btn(3, 1, 60);
        want(7, 3); want(27, 3); want(35, 3); want(43, 3); want(51, 3); want(59, 3);
        run_scn(80, 0, 1'b0, 0);

        // center held 60: one mouse_left at 7
        clear_wave(); hold_btn(0, 1, 60);
        want(7, 0);
        run_scn(80, 0, 1'b0, 0);

        // center and down together: mouse_left wins at 7, bottom repeats from 27
        clear_wave(); hold_btn(0, 1, 60); hold_btn(1, 1, 60);
        want(7, 0); want(27, 1); want(35, 1); want(43, 1); want(51, 1); want(59, 1);
        run_scn(80, 0, 1'b0, 0);

        // up held, reset pulsed before edge 5: fresh press D+3 after release
        clear_wave(); hold_btn(2, 1, 20);
        want(7, 2);
        run_scn(60, 4, 1'b0, 0);

        // randomized waveforms against the reference model
        for (int n = 0; n < 14; n++) begin
            rand_wave(100);
            run_scn(130, (n % 4 == 3) ? 3 : 0, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
